// File: rtl/sklansky_pipe_adder_if.sv
// Operand/result handshake bundle for sklansky_pipe_adder.
// slave is the adder's view; master is the producer/consumer side.
interface sklansky_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );
endinterface

// File: rtl/sklansky_pipe_adder.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready flow control and global stall.
// Define SKLANSKY_FLAGS_EN to build the registered zero/negative result flags.
module sklansky_pipe_adder #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STAGE_LEVELS = 2
) (
    input logic                 clk,
    input logic                 rst,
    sklansky_pipe_adder_if.slave bus
);
    localparam int unsigned LOG2W  = $clog2(WIDTH);
    localparam int unsigned NSTAGE = 1 + (LOG2W + STAGE_LEVELS - 1) / STAGE_LEVELS;

    // Highest index of the lower half-block that bit i joins at level l.
    function automatic int unsigned lower_idx(input int unsigned i, input int unsigned l);
        return ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
    endfunction

    logic             stall;
    logic [NSTAGE-1:0] valid_q;
    logic [WIDTH-1:0] g_q   [NSTAGE-1];
    logic [WIDTH-1:0] p_q   [NSTAGE-1];
    logic [WIDTH-1:0] ps_q  [NSTAGE-1];
    logic             cin_q [NSTAGE-1];
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    assign stall         = valid_q[NSTAGE-1] && !bus.out_ready;
    assign bus.in_ready  = !rst && !stall;
    assign bus.out_valid = valid_q[NSTAGE-1];
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_neg   = neg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (!stall) begin
            valid_q <= {valid_q[NSTAGE-2:0], bus.in_valid};
        end
    end

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] pp_in;
    logic             cin_eff;

    // Carry-in is absorbed into bit 0's group, so prefix G[i] is the carry into bit i+1.
    always_comb begin
        b_eff    = bus.in_sub ? ~bus.in_b : bus.in_b;
        cin_eff  = bus.in_sub | bus.in_cin;
        p_in     = bus.in_a ^ b_eff;
        g_in     = bus.in_a & b_eff;
        g_in[0]  = g_in[0] | (p_in[0] & cin_eff);
        pp_in    = p_in;
        pp_in[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            g_q[0]   <= g_in;
            p_q[0]   <= pp_in;
            ps_q[0]  <= p_in;
            cin_q[0] <= cin_eff;
        end
    end

    for (genvar s = 1; s < NSTAGE; s++) begin : g_stage
        localparam int unsigned LO = (s - 1) * STAGE_LEVELS;
        localparam int unsigned HI = (s * STAGE_LEVELS < LOG2W) ? s * STAGE_LEVELS : LOG2W;

        logic [WIDTH-1:0] g_c;
        logic [WIDTH-1:0] p_c;

        // In-place update is safe: the partner index never has bit l set.
        always_comb begin
            g_c = g_q[s-1];
            p_c = p_q[s-1];
            for (int unsigned l = LO; l < HI; l++) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        g_c[i] = g_c[i] | (p_c[i] & g_c[lower_idx(i, l)]);
                        p_c[i] = p_c[i] & p_c[lower_idx(i, l)];
                    end
                end
            end
        end

        if (s < NSTAGE - 1) begin : g_mid
            always_ff @(posedge clk) begin
                if (!stall) begin
                    g_q[s]   <= g_c;
                    p_q[s]   <= p_c;
                    ps_q[s]  <= ps_q[s-1];
                    cin_q[s] <= cin_q[s-1];
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] sum;

            assign sum = ps_q[s-1] ^ {g_c[WIDTH-2:0], cin_q[s-1]};

            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (!stall) begin
                    sum_q  <= sum;
                    cout_q <= g_c[WIDTH-1];
                    ovf_q  <= g_c[WIDTH-1] ^ g_c[WIDTH-2];
                end
            end

`ifdef SKLANSKY_FLAGS_EN
            always_ff @(posedge clk) begin
                if (rst) begin
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else if (!stall) begin
                    zero_q <= ~|sum;
                    neg_q  <= sum[WIDTH-1];
                end
            end
`else
            assign zero_q = 1'b0;
            assign neg_q  = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Scoreboard bench for sklansky_pipe_adder: directed corners, latency, backpressure, reset flush
// and random add/sub traffic; WIDTH/STAGE_LEVELS are overridable, SKLANSKY_FLAGS_EN optional.
module tb_sklansky_pipe_adder;
    parameter int unsigned WIDTH        = 32;
    parameter int unsigned STAGE_LEVELS = 2;

    localparam int unsigned LOG2W  = $clog2(WIDTH);
    localparam int unsigned NSTAGE = 1 + (LOG2W + STAGE_LEVELS - 1) / STAGE_LEVELS;
`ifdef SKLANSKY_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
    } res_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        res_t             r;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sklansky_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    sklansky_pipe_adder #(
        .WIDTH        (WIDTH),
        .STAGE_LEVELS (STAGE_LEVELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    stim_t stim_q[$];
    res_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] msb;
    logic [WIDTH-1:0] zero_w;

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t           r;
        logic [WIDTH:0] ext;
        logic [WIDTH-1:0] bb;
        bb     = sub ? ~b : b;
        ext    = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub | cin};
        r.sum  = ext[WIDTH-1:0];
        r.cout = ext[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        r.zero = FLAGS && (r.sum == '0);
        r.neg  = FLAGS && r.sum[WIDTH-1];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return t[WIDTH-1:0];
        endcase
    endfunction

    task automatic push_directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input res_t r);
        stim_t s;
        s.a = a; s.b = b; s.cin = cin; s.sub = sub; s.r = r;
        stim_q.push_back(s);
    endtask

    // Drives stim_q through the DUT and scores every consumed result; returns cycles used.
    task automatic stream(input bit rand_ready, input int valid_pct, input string tag,
                          output int iters);
        int    budget;
        stim_t cur;
        res_t  got;
        res_t  want;
        budget = 40 * (stim_q.size() + NSTAGE) + 200;
        iters  = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            @(negedge clk);
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stim_q.size() > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
                cur          = stim_q[0];
                bus.in_valid = 1'b1;
                bus.in_a     = cur.a;
                bus.in_b     = cur.b;
                bus.in_cin   = cur.cin;
                bus.in_sub   = cur.sub;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            checks++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                errors++;
                $display("FAIL %s in_ready: got %b want %b", tag, bus.in_ready,
                         !(bus.out_valid && !bus.out_ready));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s spurious result: got sum=%h with nothing pending", tag,
                             bus.out_sum);
                end else begin
                    want     = exp_q.pop_front();
                    got.sum  = bus.out_sum;
                    got.cout = bus.out_cout;
                    got.ovf  = bus.out_ovf;
                    got.zero = bus.out_zero;
                    got.neg  = bus.out_neg;
                    if (got !== want) begin
                        errors++;
                        $display("FAIL %s result: got sum=%h c=%b v=%b z=%b n=%b want sum=%h c=%b v=%b z=%b n=%b",
                                 tag, got.sum, got.cout, got.ovf, got.zero, got.neg,
                                 want.sum, want.cout, want.ovf, want.zero, want.neg);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                cur = stim_q.pop_front();
                exp_q.push_back(cur.r);
            end
            budget--;
            iters++;
        end
        bus.in_valid = 1'b0;
        if (budget == 0) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: got %0d pending want 0", tag, exp_q.size());
            stim_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset in_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg}
            !== '0) begin
            errors++;
            $display("FAIL reset outputs: got v=%b sum=%h c=%b o=%b z=%b n=%b want all 0",
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero,
                     bus.out_neg);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = ones;
        bus.in_b      = {{(WIDTH-1){1'b0}}, 1'b1};
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != int'(NSTAGE)) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", lat, NSTAGE);
        end
        checks++;
        if ({bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg}
            !== {zero_w, 1'b1, 1'b0, FLAGS, 1'b0}) begin
            errors++;
            $display("FAIL wrap add: got sum=%h c=%b v=%b z=%b n=%b want sum=0 c=1 v=0 z=%b n=0",
                     bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg, FLAGS);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single beat consumed: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_directed();
        int n;
        push_directed(msb, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b1,
                      '{sum: ~msb, cout: 1'b1, ovf: 1'b1, zero: 1'b0, neg: 1'b0});
        push_directed(zero_w, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b1,
                      '{sum: ones, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: FLAGS});
        push_directed(WIDTH'(5), WIDTH'(3), 1'b1, 1'b0,
                      '{sum: WIDTH'(9), cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
        push_directed(WIDTH'(5), WIDTH'(3), 1'b1, 1'b1,
                      '{sum: WIDTH'(2), cout: 1'b1, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
        push_directed(~msb, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b0,
                      '{sum: msb, cout: 1'b0, ovf: 1'b1, zero: 1'b0, neg: FLAGS});
        push_directed(ones, ones, 1'b0, 1'b1,
                      '{sum: zero_w, cout: 1'b1, ovf: 1'b0, zero: FLAGS, neg: 1'b0});
        stream(1'b0, 100, "directed", n);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic cin;
        logic sub;
        for (int i = 0; i < 16; i++) begin
            a   = rand_word();
            b   = rand_word();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            push_directed(a, b, cin, sub, model(a, b, cin, sub));
        end
        stream(1'b1, 100, "back_to_back", n);
    endtask

    task automatic test_throughput();
        int n;
        for (int i = 0; i < 32; i++) begin
            push_directed(WIDTH'(i), WIDTH'(3 * i + 1), 1'b0, 1'b0,
                          '{sum: WIDTH'(4 * i + 1), cout: 1'b0, ovf: 1'b0, zero: 1'b0,
                            neg: 1'b0});
        end
        stream(1'b0, 100, "throughput", n);
        checks++;
        if (n != 32 + int'(NSTAGE)) begin
            errors++;
            $display("FAIL throughput cycles: got %0d want %0d", n, 32 + NSTAGE);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        int n;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_a      = rand_word();
            bus.in_b      = rand_word();
            bus.in_cin    = 1'b0;
            bus.in_sub    = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid reset in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush: got %0d cycles with out_valid want 0", seen);
        end
        push_directed(WIDTH'(7), WIDTH'(7), 1'b0, 1'b1,
                      '{sum: zero_w, cout: 1'b1, ovf: 1'b0, zero: FLAGS, neg: 1'b0});
        stream(1'b0, 100, "after_reset", n);
    endtask

    task automatic test_random();
        int n;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic cin;
        logic sub;
        for (int i = 0; i < 2000; i++) begin
            a   = rand_word();
            b   = rand_word();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            push_directed(a, b, cin, sub, model(a, b, cin, sub));
        end
        stream(1'b1, 70, "random", n);
    endtask

    initial begin
        ones          = '1;
        zero_w        = '0;
        msb           = {1'b1, {(WIDTH-1){1'b0}}};
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_throughput();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sklansky_pipe_adder.md
Name: sklansky_pipe_adder

Overview:
Parametrised, pipelined Sklansky parallel-prefix adder/subtractor for the ALU datapath. It generalises the fixed 32-bit combinational Sklansky carry generator in three ways: any power-of-two width, configurable prefix levels per pipeline stage, and add/subtract mode. Operands enter on a valid/ready handshake and results leave on one with full backpressure. Intended as the ALU's arithmetic unit when the combinational carry path does not meet timing.

Parameters:
WIDTH, 32, operand width; power of two, 8..64.
STAGE_LEVELS, 2, prefix levels per pipeline stage; 1..log2(WIDTH).
LOG2W, log2(WIDTH), derived, not overridable.
NSTAGE, 1 + ceil(LOG2W/STAGE_LEVELS), derived; total pipeline depth and latency in cycles.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in; ignored when in_sub=1
in_sub  in  1  1: A-B (A + ~B + 1); 0: A+B+cin
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_sum  out  WIDTH  sum or difference
out_cout  out  1  carry out of MSB; in subtract mode 1 = no borrow
out_ovf  out  1  signed two's-complement overflow
out_zero  out  1  out_sum == 0 (see Optional Feature)
out_neg  out  1  out_sum[WIDTH-1] (see Optional Feature)

Behaviour:
- Reset: all stage valid bits, out_valid and all result registers (out_sum, out_cout, out_ovf, out_zero, out_neg) go to 0 on the first clk edge with rst=1. in_ready is forced 0 while rst=1.
- Accept: a beat is accepted when in_valid && in_ready. Output is consumed when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !rst && !stall. When stalled, every stage register, including the valid bits, holds. Stall is global and bubbles are not squeezed out.
- Stage 1 registers operand-effective B (~in_b if in_sub), effective cin (1 if in_sub), bitwise g=a&b', p=a^b', and the MSB sign bits of A and B'. Carry-in is folded in as group (g,p) at position -1, so prefix bit i yields carry into bit i+1.
- Stages 2..NSTAGE each evaluate STAGE_LEVELS Sklansky levels, then register. At level k, bits whose index has bit k set combine with the group ending at the highest index of the lower half-block. The last stage may hold fewer levels.
- Final stage forms sum = p ^ {carry[WIDTH-2:0],cin}, cout = carry[WIDTH-1], ovf = carry[WIDTH-1] ^ carry[WIDTH-2], and registers all outputs.
- Latency: exactly NSTAGE cycles from acceptance to out_valid when there is no stall. Each stall cycle adds exactly one cycle.
- Throughput: one beat per cycle with out_ready held at 1.
- Ordering: results leave strictly in acceptance order, with no drop or duplication.
- Simultaneous accept and consume in the same cycle is legal and is the full-throughput case.
- Invalid stages may carry don't-care data. Outputs are only meaningful while out_valid=1.
- rst mid-operation flushes all in-flight beats. out_valid=0 from the following cycle, and no pre-reset result ever appears.

Optional Feature:
SKLANSKY_FLAGS_EN
- Defined: out_zero and out_neg are registered with the result. out_zero comes from a zero-detect reduction on the final sum, placed inside the final stage.
- Undefined: the out_zero and out_neg ports still exist but are tied to 0, and no reduction logic is built.

Test Plan:
1. WIDTH=32, STAGE_LEVELS=2 (NSTAGE=4). Add 0xFFFFFFFF+0x00000001, cin=0 → out_sum=0x00000000, cout=1, ovf=0, zero=1 (flags on). out_valid rises exactly 4 cycles after accept.
2. Subtract 0x80000000-0x00000001 → out_sum=0x7FFFFFFF, cout=1, ovf=1, neg=0. Subtract 0x00000000-0x00000001 → 0xFFFFFFFF, cout=0, ovf=0, neg=1.
3. Sixteen back-to-back beats with out_ready toggling pseudo-randomly → results in order, none lost or duplicated. in_ready=0 exactly on the cycles where out_valid && !out_ready.
4. Three beats in flight, then rst for 1 cycle → out_valid=0 the next cycle and stays 0 until new beats complete. in_ready=0 during rst.
5. Parameter sweep (8,1), (16,4), (64,3) with 10k random add/sub beats → matches a behavioural A±B model on sum, cout and ovf. Latency equals 1+ceil(LOG2W/STAGE_LEVELS): 4, 2 and 3 respectively.
6. Build without SKLANSKY_FLAGS_EN and repeat test 1 → sum, cout and ovf are unchanged, and out_zero=out_neg=0.
